// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM encoding for the UART command responder.
// Holds protocol opcodes, reply codes, the FSM state enum and a helper
// that sizes the register index. Optional macro UART_CMD_CHKSUM_EN adds
// the GET_CHK state for checksum-terminated frames.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
`ifdef UART_CMD_CHKSUM_EN
    ST_GET_CHK  = 3'd3,
`endif
    ST_EXEC     = 3'd4,
    ST_SEND     = 3'd5
  } state_t;

  // State entered after the last payload byte of a W/R frame.
`ifdef UART_CMD_CHKSUM_EN
  localparam state_t ST_AFTER_PAYLOAD = ST_GET_CHK;
`else
  localparam state_t ST_AFTER_PAYLOAD = ST_EXEC;
`endif

  // Register index width; a single-register bank still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_regbank.sv
// Bank of NUM_REGS 8-bit control registers with a single write port.
// Ports: clk, rst (async active-low clear), we/addr/wdata write port,
// reg_q flattened contents (reg N at bits [8N+7:8N]).
module uart_cmd_regbank #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IW       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IW-1:0]         addr,
  input  logic [7:0]            wdata,
  output logic [NUM_REGS*8-1:0] reg_q
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [7:0] q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q <= 8'h00;
      end else if (we && (addr == IW'(i))) begin
        q <= wdata;
      end
    end

    assign reg_q[i*8 +: 8] = q;
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-framed register read/write responder sitting behind a UART.
// Frames: 'W' ADDR DATA -> ACK, 'R' ADDR -> register value, other -> NAK.
// Optional macro UART_CMD_CHKSUM_EN appends an XOR checksum byte to W/R frames.
// Ports: clk_50m, rst (async active-low); rx_data/rx_rdy/rx_rdy_clr from the
// receiver; tx_data/tx_wr_en/tx_busy to the transmitter; reg_q flattened
// register bank; wr_stb/wr_addr pulse on every register write.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_rdy_clr,
  output logic [7:0]            tx_data,
  output logic                  tx_wr_en,
  input  logic                  tx_busy,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_stb,
  output logic [7:0]            wr_addr
);

  localparam int unsigned IW = idx_width(NUM_REGS);
  localparam int unsigned TW = 32;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic            bad_q, bad_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            clr_q, clr_d;
  logic            txw_q, txw_d;
  logic            wr_stb_q, wr_stb_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            reg_we;
  logic            accept;
  logic            in_range;
  logic            tmo_hit;
  logic [IW-1:0]   idx;
  logic [7:0]      rd_byte;

  // rx_rdy stays high for one cycle after our clear pulse; ignore it then.
  assign accept   = rx_rdy && !clr_q;
  assign in_range = (32'(addr_q) < NUM_REGS);
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign idx      = addr_q[IW-1:0];

  // Read mux over the flattened bank.
  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (idx == IW'(i)) rd_byte = reg_q[i*8 +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    bad_d     = bad_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    wr_addr_d = wr_addr_q;
    clr_d     = 1'b0;
    txw_d     = 1'b0;
    wr_stb_d  = 1'b0;
    reg_we    = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (accept) begin
          clr_d   = 1'b1;
          is_wr_d = (rx_data == OP_WR);
`ifdef UART_CMD_CHKSUM_EN
          csum_d  = rx_data;
`endif
          if ((rx_data == OP_WR) || (rx_data == OP_RD)) begin
            bad_d   = 1'b0;
            state_d = ST_GET_ADDR;
          end else begin
            bad_d   = 1'b1;
            state_d = ST_EXEC;
          end
        end
      end

      ST_GET_ADDR: begin
        if (accept) begin
          clr_d  = 1'b1;
          tmo_d  = '0;
          addr_d = rx_data;
`ifdef UART_CMD_CHKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          state_d = is_wr_q ? ST_GET_DATA : ST_AFTER_PAYLOAD;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_GET_DATA: begin
        if (accept) begin
          clr_d  = 1'b1;
          tmo_d  = '0;
          data_d = rx_data;
`ifdef UART_CMD_CHKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          state_d = ST_AFTER_PAYLOAD;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

`ifdef UART_CMD_CHKSUM_EN
      ST_GET_CHK: begin
        if (accept) begin
          clr_d   = 1'b1;
          tmo_d   = '0;
          if (rx_data != csum_q) bad_d = 1'b1;
          state_d = ST_EXEC;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`endif

      // Range check happens before the address is used as an index.
      ST_EXEC: begin
        state_d = ST_SEND;
        if (bad_q || !in_range) begin
          tx_data_d = NAK;
        end else if (is_wr_q) begin
          reg_we    = 1'b1;
          wr_stb_d  = 1'b1;
          wr_addr_d = addr_q;
          tx_data_d = ACK;
        end else begin
          tx_data_d = rd_byte;
        end
      end

      ST_SEND: begin
        if (!tx_busy) begin
          txw_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      bad_q     <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      tmo_q     <= '0;
      tx_data_q <= 8'h00;
      clr_q     <= 1'b0;
      txw_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 8'h00;
`ifdef UART_CMD_CHKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      bad_q     <= bad_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      clr_q     <= clr_d;
      txw_q     <= txw_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
`ifdef UART_CMD_CHKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign rx_rdy_clr = clr_q;
  assign tx_data    = tx_data_q;
  assign tx_wr_en   = txw_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;

  uart_cmd_regbank #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW)
  ) u_regbank (
    .clk   (clk_50m),
    .rst   (rst),
    .we    (reg_we),
    .addr  (idx),
    .wdata (data_q),
    .reg_q (reg_q)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder with a frame-level reference
// model (register array + protocol rules). Honors UART_CMD_CHKSUM_EN.
`timescale 1ns/1ps
module tb_uart_cmd_responder;

  localparam int unsigned NREG = 16;
  localparam int unsigned TMO  = 300;

  typedef logic [7:0] bq_t [$];

  logic              clk_50m = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              rx_rdy_clr;
  logic [7:0]        tx_data;
  logic              tx_wr_en;
  logic              tx_busy;
  logic [NREG*8-1:0] reg_q;
  logic              wr_stb;
  logic [7:0]        wr_addr;

  int total = 0;
  int bad   = 0;

  logic [7:0] mregs [NREG];

  int         cyc     = 0;
  int         tx_cyc  = 0;
  int         clr_cyc = 0;
  logic [7:0] tx_q [$];
  logic [7:0] wr_q [$];

  uart_cmd_responder #(
    .NUM_REGS       (NREG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .tx_data    (tx_data),
    .tx_wr_en   (tx_wr_en),
    .tx_busy    (tx_busy),
    .reg_q      (reg_q),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr)
  );

  always #10 clk_50m = ~clk_50m;

  // Event recorder sampled on the inactive edge.
  always @(negedge clk_50m) begin
    cyc = cyc + 1;
    if (tx_wr_en) begin
      tx_q.push_back(tx_data);
      tx_cyc = cyc;
    end
    if (rx_rdy_clr) clr_cyc = cyc;
    if (wr_stb) wr_q.push_back(wr_addr);
  end

  task automatic tick();
    @(negedge clk_50m);
    #1;
  endtask

  function automatic logic [NREG*8-1:0] model_flat();
    logic [NREG*8-1:0] f;
    for (int i = 0; i < int'(NREG); i++) f[i*8 +: 8] = mregs[i];
    return f;
  endfunction

  function automatic bq_t build(input logic [7:0] op, input logic [7:0] ad, input logic [7:0] dt);
    bq_t fr;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] x;
`endif
    fr = {};
    fr.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      fr.push_back(ad);
      if (op == 8'h57) fr.push_back(dt);
`ifdef UART_CMD_CHKSUM_EN
      x = 8'h00;
      foreach (fr[i]) x = x ^ fr[i];
      fr.push_back(x);
`endif
    end
    return fr;
  endfunction

  // Protocol reference: returns expected reply and write, updates mregs.
  task automatic model_frame(input bq_t fr, output logic [7:0] rep, output bit wr, output logic [7:0] wa);
    logic [7:0] op, ad;
    bit ok;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] x;
`endif
    op = fr[0];
    wr = 1'b0;
    wa = 8'h00;
    ok = (op == 8'h57 || op == 8'h52);
`ifdef UART_CMD_CHKSUM_EN
    if (ok) begin
      x = 8'h00;
      for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
      ok = (x == fr[fr.size()-1]);
    end
`endif
    ad = (fr.size() > 1) ? fr[1] : 8'h00;
    if (ok && int'(ad) >= int'(NREG)) ok = 1'b0;
    if (!ok) begin
      rep = 8'h15;
    end else if (op == 8'h57) begin
      mregs[int'(ad)] = fr[2];
      wr  = 1'b1;
      wa  = ad;
      rep = 8'h06;
    end else begin
      rep = mregs[int'(ad)];
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    tick();
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rx_rdy_clr) begin
        rx_rdy = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) rx_rdy = 1'b0;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sends one frame (optional gap before its last byte) and checks the outcome.
  task automatic do_frame(input bq_t fr, input int gap, input string nm);
    logic [7:0] er, wa, got;
    bit ew, ok, all;
    int n;
    model_frame(fr, er, ew, wa);
    tx_q.delete();
    wr_q.delete();
    all = 1'b1;
    n = fr.size();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) repeat (gap) tick();
      send_byte(fr[i], ok);
      all = all & ok;
    end
    total++;
    if (!all) begin
      bad++;
      $display("FAIL %s consume: bytes not all taken, got %0d want 1", nm, all);
    end
    wait_tx(ok);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    total++;
    if (got !== er) begin
      bad++;
      $display("FAIL %s reply: got %02h want %02h", nm, got, er);
    end
    total++;
    if ((tx_cyc - clr_cyc) !== 2) begin
      bad++;
      $display("FAIL %s latency: got %0d want 2", nm, tx_cyc - clr_cyc);
    end
    repeat (3) tick();
    total++;
    if (tx_q.size() !== 1) begin
      bad++;
      $display("FAIL %s tx_count: got %0d want 1", nm, tx_q.size());
    end
    total++;
    if (wr_q.size() !== (ew ? 1 : 0)) begin
      bad++;
      $display("FAIL %s wr_count: got %0d want %0d", nm, wr_q.size(), ew ? 1 : 0);
    end
    if (ew && wr_q.size() > 0) begin
      total++;
      if (wr_q[0] !== wa) begin
        bad++;
        $display("FAIL %s wr_addr: got %02h want %02h", nm, wr_q[0], wa);
      end
    end
    total++;
    if (reg_q !== model_flat()) begin
      bad++;
      $display("FAIL %s reg_q: got %h want %h", nm, reg_q, model_flat());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < int'(NREG); i++) mregs[i] = 8'h00;
    rst = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
    repeat (3) tick();
    total++; if (reg_q !== '0) begin bad++; $display("FAIL reset reg_q: got %h want 0", reg_q); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data: got %02h want 00", tx_data); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL reset wr_addr: got %02h want 00", wr_addr); end
    total++; if ({rx_rdy_clr, tx_wr_en, wr_stb} !== 3'b000) begin
      bad++; $display("FAIL reset strobes: got %b want 000", {rx_rdy_clr, tx_wr_en, wr_stb});
    end
    rst = 1'b1;
    repeat (2) tick();
    total++; if ({rx_rdy_clr, tx_wr_en, wr_stb} !== 3'b000) begin
      bad++; $display("FAIL post_reset strobes: got %b want 000", {rx_rdy_clr, tx_wr_en, wr_stb});
    end
  endtask

  task automatic test_write_read();
    do_frame(build(8'h57, 8'h03, 8'hA5), 0, "wr03");
    total++; if (reg_q[31:24] !== 8'hA5) begin bad++; $display("FAIL wr03 reg3: got %02h want a5", reg_q[31:24]); end
    do_frame(build(8'h52, 8'h03, 8'h00), 0, "rd03");
  endtask

  task automatic test_bad_opcode();
    bq_t fr;
    fr = {8'h41};
    do_frame(fr, 0, "badop");
    do_frame(build(8'h52, 8'h03, 8'h00), 0, "rd_after_badop");
  endtask

  task automatic test_address_range();
    do_frame(build(8'h57, 8'h10, 8'hFF), 0, "wr_oor");
    do_frame(build(8'h52, 8'hFF, 8'h00), 0, "rd_oor");
    do_frame(build(8'h57, 8'h0F, 8'h9E), 0, "wr_last");
    do_frame(build(8'h52, 8'h0F, 8'h00), 0, "rd_last");
  endtask

  task automatic test_timeout();
    bit ok;
    tx_q.delete();
    wr_q.delete();
    send_byte(8'h57, ok);
    send_byte(8'h02, ok);
    repeat (TMO + 20) tick();
    total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL timeout tx: got %0d want 0", tx_q.size()); end
    total++; if (wr_q.size() !== 0) begin bad++; $display("FAIL timeout wr: got %0d want 0", wr_q.size()); end
    do_frame(build(8'h52, 8'h02, 8'h00), 0, "rd_after_timeout");
    do_frame(build(8'h57, 8'h05, 8'h77), int'(TMO) - 40, "slow_frame");
  endtask

  task automatic test_random();
    logic [7:0] op, ad, dt;
    int r;
    bq_t fr;
    for (int k = 0; k < 24; k++) begin
      r  = int'($urandom_range(0, 9));
      ad = 8'($urandom_range(0, 19));
      dt = 8'($urandom);
      if (r < 5) op = 8'h57;
      else if (r < 9) op = 8'h52;
      else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h41;
      end
      fr = build(op, ad, dt);
`ifdef UART_CMD_CHKSUM_EN
      if (fr.size() > 1 && $urandom_range(0, 5) == 0) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'hFF;
`endif
      do_frame(fr, int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_back_to_back();
    bq_t fr, rf;
    logic [7:0] er, er2, wa, got;
    bit ew, ok;
    int fall, clr0;
    fr = build(8'h57, 8'h07, 8'h5A);
    model_frame(fr, er, ew, wa);
    tx_q.delete();
    tx_busy = 1'b1;
    foreach (fr[i]) send_byte(fr[i], ok);
    tick();
    rx_data = 8'h52;
    rx_rdy  = 1'b1;
    clr0 = clr_cyc;
    repeat (100) tick();
    total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL bp_hold tx: got %0d want 0", tx_q.size()); end
    total++; if (clr_cyc !== clr0) begin bad++; $display("FAIL bp_hold consumed: got cycle %0d want %0d", clr_cyc, clr0); end
    tx_busy = 1'b0;
    fall = cyc;
    wait_tx(ok);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    total++; if (got !== er) begin bad++; $display("FAIL bp reply: got %02h want %02h", got, er); end
    total++; if ((tx_cyc - fall) !== 1) begin bad++; $display("FAIL bp latency: got %0d want 1", tx_cyc - fall); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rx_rdy_clr) begin rx_rdy = 1'b0; ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL bp queued_byte: taken=%0d want 1", ok); end
    total++; if (tx_q.size() !== 1) begin bad++; $display("FAIL bp tx_once: got %0d want 1", tx_q.size()); end
    rf = build(8'h52, 8'h07, 8'h00);
    model_frame(rf, er2, ew, wa);
    tx_q.delete();
    for (int i = 1; i < rf.size(); i++) send_byte(rf[i], ok);
    wait_tx(ok);
    got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
    total++; if (got !== er2) begin bad++; $display("FAIL bp queued_read: got %02h want %02h", got, er2); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    do_frame(build(8'h57, 8'h01, 8'hC3), 0, "wr01");
    tx_q.delete();
    send_byte(8'h57, ok);
    send_byte(8'h01, ok);
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < int'(NREG); i++) mregs[i] = 8'h00;
    total++; if (reg_q !== '0) begin bad++; $display("FAIL midrst reg_q: got %h want 0", reg_q); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL midrst tx_data: got %02h want 00", tx_data); end
    total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL midrst wr_addr: got %02h want 00", wr_addr); end
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL midrst tx: got %0d want 0", tx_q.size()); end
    do_frame(build(8'h52, 8'h01, 8'h00), 0, "rd01_after_reset");
  endtask

`ifdef UART_CMD_CHKSUM_EN
  task automatic test_chksum();
    bq_t fr;
    fr = {8'h57, 8'h04, 8'h3C, 8'h6F};
    do_frame(fr, 0, "chk_good");
    total++; if (reg_q[39:32] !== 8'h3C) begin bad++; $display("FAIL chk_good reg4: got %02h want 3c", reg_q[39:32]); end
    fr = {8'h57, 8'h04, 8'h99, 8'h00};
    do_frame(fr, 0, "chk_bad");
    total++; if (reg_q[39:32] !== 8'h3C) begin bad++; $display("FAIL chk_bad reg4: got %02h want 3c", reg_q[39:32]); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_bad_opcode();
    test_address_range();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_CMD_CHKSUM_EN
    test_chksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
